// File: rtl/commit_trace_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | commit_trace_pkg                                                   |
// | Shared types and constants for the commit trace buffer: the packed |
// | retire record, its width and the flag bit positions.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package commit_trace_pkg;

  // Record field width; the buffer's XLEN parameter must match this.
  localparam int TRACE_XLEN = 32;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] inst;
    logic [TRACE_XLEN-1:0] gpr_wdata;
    logic [TRACE_XLEN-1:0] cause;
    logic [4:0]            gpr_waddr;
    logic                  gpr_wen;
    logic                  trap;
    logic                  ebreak;
    logic                  ivd;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Bit positions of the single-bit flags inside a packed record.
  localparam int FLAG_IVD     = 0;
  localparam int FLAG_EBREAK  = 1;
  localparam int FLAG_TRAP    = 2;
  localparam int FLAG_GPR_WEN = 3;

endpackage
`default_nettype wire

// File: rtl/commit_trace_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | commit_trace_buf_if                                                |
// | Commit-group input bus and record drain port of the trace buffer.  |
// | master = commit stage + consumer side, slave = trace buffer.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface commit_trace_buf_if
  import commit_trace_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int XLEN  = TRACE_XLEN,
  parameter int DEPTH = 16
);
  logic [NCH-1:0]      cm_valid;
  logic [NCH*XLEN-1:0] cm_pc;
  logic [NCH*XLEN-1:0] cm_inst;
  logic [NCH*XLEN-1:0] cm_gpr_wdata;
  logic [NCH*XLEN-1:0] cm_cause;
  logic [NCH-1:0]      cm_gpr_wen;
  logic [NCH-1:0]      cm_trap;
  logic [NCH-1:0]      cm_ebreak;
  logic [NCH-1:0]      cm_ivd;
  logic [NCH*5-1:0]    cm_gpr_waddr;
  logic                cm_ready;

  logic                out_valid;
  logic                out_ready;
  trace_rec_t          out_rec;

  logic [$clog2(DEPTH):0] count;
  logic                   halted;
  logic                   ovf;

  modport master (
    output cm_valid, cm_pc, cm_inst, cm_gpr_wdata, cm_cause,
           cm_gpr_wen, cm_trap, cm_ebreak, cm_ivd, cm_gpr_waddr, out_ready,
    input  cm_ready, out_valid, out_rec, count, halted, ovf
  );

  modport slave (
    input  cm_valid, cm_pc, cm_inst, cm_gpr_wdata, cm_cause,
           cm_gpr_wen, cm_trap, cm_ebreak, cm_ivd, cm_gpr_waddr, out_ready,
    output cm_ready, out_valid, out_rec, count, halted, ovf
  );
endinterface
`default_nettype wire

// File: rtl/commit_trace_buf_compact.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | commit_compact                                                     |
// | Per-channel slot offset (prefix popcount of lower valid channels)  |
// | and total number of valid channels in a commit group.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module commit_compact #(
  parameter int NCH = 2,
  parameter int OW  = $clog2(NCH) + 1
) (
  input  logic [NCH-1:0]    valid,
  output logic [NCH*OW-1:0] slot_ofs,
  output logic [OW-1:0]     total
);
  logic [OW-1:0] acc;

  // Running count: each channel lands after all lower-indexed valid ones.
  always_comb begin
    slot_ofs = '0;
    acc      = '0;
    for (int i = 0; i < NCH; i++) begin
      slot_ofs[i*OW +: OW] = acc;
      acc = acc + OW'(valid[i]);
    end
    total = acc;
  end
endmodule
`default_nettype wire

// File: rtl/commit_trace_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | commit_trace_buf                                                   |
// | Multi-channel retire-record ring: all-or-nothing group push with   |
// | compaction, one-per-cycle drain, sticky halt on ebreak/invalid     |
// | drain, sticky overflow on refused groups.                          |
// | Optional macro COMMIT_TRACE_PERF_EN adds 64-bit perf counters.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module commit_trace_buf
  import commit_trace_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int XLEN  = TRACE_XLEN
) (
  input  logic        clk,
  input  logic        reset,
  commit_trace_buf_if.slave bus
`ifdef COMMIT_TRACE_PERF_EN
  ,
  input  logic        bp_hit,
  input  logic        bp_miss,
  input  logic        exu_valid,
  output logic [63:0] perf_bp_hit,
  output logic [63:0] perf_bp_miss,
  output logic [63:0] perf_exu_busy
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(NCH) + 1;

  trace_rec_t       mem [DEPTH];
  trace_rec_t       in_rec [NCH];
  trace_rec_t       head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             halted_q;
  logic             ovf_q;
  logic [NCH*OW-1:0] slot_ofs;
  logic [OW-1:0]    push_cnt;
  logic             ready;
  logic             push;
  logic             pop;

  commit_compact #(.NCH(NCH), .OW(OW)) u_compact (
    .valid    (bus.cm_valid),
    .slot_ofs (slot_ofs),
    .total    (push_cnt)
  );

  // Readiness is from registered occupancy only; held low while in reset.
  assign ready = reset && !halted_q && ((CW'(DEPTH) - count_q) >= CW'(NCH));
  assign push  = ready && (|bus.cm_valid);
  assign pop   = (count_q != '0) && bus.out_ready;
  assign head  = mem[rd_ptr];

  assign bus.cm_ready  = ready;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_rec   = head;
  assign bus.count     = count_q;
  assign bus.halted    = halted_q;
  assign bus.ovf       = ovf_q;

  // Unpack each channel's flat fields into a record; cause only kept for traps.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      in_rec[i]           = '0;
      in_rec[i].pc        = bus.cm_pc[i*XLEN +: XLEN];
      in_rec[i].inst      = bus.cm_inst[i*XLEN +: XLEN];
      in_rec[i].gpr_wdata = bus.cm_gpr_wdata[i*XLEN +: XLEN];
      in_rec[i].cause     = bus.cm_trap[i] ? bus.cm_cause[i*XLEN +: XLEN] : '0;
      in_rec[i].gpr_waddr = bus.cm_gpr_waddr[i*5 +: 5];
      in_rec[i].gpr_wen   = bus.cm_gpr_wen[i];
      in_rec[i].trap      = bus.cm_trap[i];
      in_rec[i].ebreak    = bus.cm_ebreak[i];
      in_rec[i].ivd       = bus.cm_ivd[i];
    end
  end

  // Ring storage: valid channels written to compacted slots after wr_ptr.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push && bus.cm_valid[i]) begin
        mem[wr_ptr + AW'(slot_ofs[i*OW +: OW])] <= in_rec[i];
      end
    end
  end

  // Pointers, occupancy and sticky halt/overflow status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(push_cnt);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (push ? CW'(push_cnt) : CW'(0)) - CW'(pop);
      if (pop && (head[FLAG_EBREAK] || head[FLAG_IVD])) halted_q <= 1'b1;
      if ((|bus.cm_valid) && !ready) ovf_q <= 1'b1;
    end
  end

`ifdef COMMIT_TRACE_PERF_EN
  // Free-running event counters, independent of halt; wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_bp_hit   <= '0;
      perf_bp_miss  <= '0;
      perf_exu_busy <= '0;
    end else begin
      if (bp_hit)    perf_bp_hit   <= perf_bp_hit + 64'd1;
      if (bp_miss)   perf_bp_miss  <= perf_bp_miss + 64'd1;
      if (exu_valid) perf_exu_busy <= perf_exu_busy + 64'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_commit_trace_buf                                                |
// | Directed self-checking bench for commit_trace_buf (NCH=2, DEPTH=16)|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_commit_trace_buf;
  import commit_trace_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   max_count = 0;
  trace_rec_t popped[$];

`ifdef COMMIT_TRACE_PERF_EN
  logic        bp_hit = 1'b0;
  logic        bp_miss = 1'b0;
  logic        exu_valid = 1'b0;
  logic [63:0] perf_bp_hit;
  logic [63:0] perf_bp_miss;
  logic [63:0] perf_exu_busy;
`endif

  commit_trace_buf_if #(.NCH(2), .XLEN(32), .DEPTH(16)) bus ();

  commit_trace_buf #(.NCH(2), .DEPTH(16), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef COMMIT_TRACE_PERF_EN
    ,
    .bp_hit        (bp_hit),
    .bp_miss       (bp_miss),
    .exu_valid     (exu_valid),
    .perf_bp_hit   (perf_bp_hit),
    .perf_bp_miss  (perf_bp_miss),
    .perf_exu_busy (perf_exu_busy)
`endif
  );

  always #5 clk = ~clk;

  // Record every handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) popped.push_back(bus.out_rec);
    if (int'(bus.count) > max_count) max_count = int'(bus.count);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  // Present one commit group for one cycle; flags set beforehand by caller.
  task automatic push(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    bus.cm_valid     = v;
    bus.cm_pc        = {pc1, pc0};
    bus.cm_inst      = {32'h0010_0093, 32'h0000_0013};
    bus.cm_gpr_wdata = {pc1 + 32'h1, pc0 + 32'h1};
    bus.cm_gpr_wen   = 2'b11;
    bus.cm_gpr_waddr = {5'd2, 5'd1};
    @(posedge clk);
    #1;
    bus.cm_valid  = '0;
    bus.cm_trap   = '0;
    bus.cm_ebreak = '0;
    bus.cm_ivd    = '0;
    bus.cm_cause  = '0;
  endtask

  initial begin
    bus.cm_valid = '0; bus.cm_pc = '0; bus.cm_inst = '0; bus.cm_gpr_wdata = '0;
    bus.cm_cause = '0; bus.cm_gpr_wen = '0; bus.cm_trap = '0; bus.cm_ebreak = '0;
    bus.cm_ivd = '0; bus.cm_gpr_waddr = '0; bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_cm_ready", bus.cm_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_ovf", bus.ovf, 0);
    reset = 1'b1;
    #1;
    check("post_rst_cm_ready", bus.cm_ready, 1);

    // Full groups with idle gaps, drained in order
    popped.delete();
    max_count = 0;
    bus.out_ready = 1'b1;
    push(2'b11, 32'h8000_0000, 32'h8000_0004);
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_pc", bus.out_rec.pc, 64'h8000_0000);
    idle(1);
    push(2'b11, 32'h8000_0008, 32'h8000_000C);
    idle(1);
    push(2'b11, 32'h8000_0010, 32'h8000_0014);
    idle(8);
    check("t1_n_popped", popped.size(), 6);
    for (int k = 0; k < popped.size(); k++)
      check($sformatf("t1_pc%0d", k), popped[k].pc, 64'h8000_0000 + 64'(4 * k));
    check("t1_max_count", max_count, 2);
    check("t1_ovf", bus.ovf, 0);
    check("t1_count", bus.count, 0);

    // Sparse patterns get compacted; cause only kept for trap records
    popped.delete();
    bus.cm_trap  = 2'b10;
    bus.cm_cause = {32'h0000_000B, 32'h0000_0077};
    push(2'b10, 32'hDEAD_0000, 32'h0000_0100);
    bus.cm_cause = {32'h0000_0066, 32'h0000_0055};
    push(2'b01, 32'h0000_0200, 32'h0000_0999);
    idle(4);
    check("t2_n_popped", popped.size(), 2);
    if (popped.size() == 2) begin
      check("t2_pc0", popped[0].pc, 64'h100);
      check("t2_cause0", popped[0].cause, 64'hB);
      check("t2_trap0", popped[0].trap, 1);
      check("t2_waddr0", popped[0].gpr_waddr, 2);
      check("t2_pc1", popped[1].pc, 64'h200);
      check("t2_cause1", popped[1].cause, 0);
      check("t2_waddr1", popped[1].gpr_waddr, 1);
    end

    // Fill to full, overflow, then drain across the wrap
    popped.delete();
    bus.out_ready = 1'b0;
    for (int g = 0; g < 8; g++)
      push(2'b11, 32'h1000 + 32'(8 * g), 32'h1004 + 32'(8 * g));
    check("t3_count_full", bus.count, 16);
    check("t3_cm_ready_full", bus.cm_ready, 0);
    check("t3_ovf_before", bus.ovf, 0);
    push(2'b11, 32'h0BAD, 32'h0BAD);
    check("t3_ovf", bus.ovf, 1);
    check("t3_count_kept", bus.count, 16);
    check("t3_head_pc", bus.out_rec.pc, 64'h1000);
    bus.out_ready = 1'b1;
    idle(18);
    check("t3_n_popped", popped.size(), 16);
    for (int k = 0; k < popped.size(); k++)
      check($sformatf("t3_pc%0d", k), popped[k].pc, 64'h1000 + 64'(4 * k));
    check("t3_count_end", bus.count, 0);

    // Ebreak halts after it drains; trailing record still drains
    do_reset();
    check("t4_ovf_cleared", bus.ovf, 0);
    popped.delete();
    bus.cm_ebreak = 2'b01;
    push(2'b11, 32'h8000_0040, 32'h8000_0044);
    check("t4_halted_early", bus.halted, 0);
    idle(1);
    check("t4_halted", bus.halted, 1);
    check("t4_cm_ready", bus.cm_ready, 0);
    check("t4_trail_valid", bus.out_valid, 1);
    check("t4_trail_pc", bus.out_rec.pc, 64'h8000_0044);
    idle(1);
    check("t4_count_drained", bus.count, 0);
    push(2'b01, 32'h0000_0300, 32'h0);
    check("t4_ovf", bus.ovf, 1);
    check("t4_count_refused", bus.count, 0);
    check("t4_n_popped", popped.size(), 2);

    // Reset clears halt/ovf, then reset mid-drain discards entries
    do_reset();
    check("t5_halted_clr", bus.halted, 0);
    check("t5_ovf_clr", bus.ovf, 0);
    check("t5_cm_ready", bus.cm_ready, 1);
    bus.out_ready = 1'b0;
    push(2'b11, 32'h10, 32'h14);
    push(2'b11, 32'h18, 32'h1C);
    push(2'b11, 32'h20, 32'h24);
    bus.out_ready = 1'b1;
    idle(1);
    check("t5_count5", bus.count, 5);
    do_reset();
    check("t5_count0", bus.count, 0);
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_halted", bus.halted, 0);
    check("t5_ovf", bus.ovf, 0);
    check("t5_cm_ready_after", bus.cm_ready, 1);

`ifdef COMMIT_TRACE_PERF_EN
    // Perf counters count high cycles and clear on reset
    bp_hit = 1'b1; bp_miss = 1'b1; exu_valid = 1'b1;
    idle(2);
    exu_valid = 1'b0;
    idle(1);
    bp_miss = 1'b0;
    idle(7);
    bp_hit = 1'b0;
    idle(1);
    check("perf_bp_hit", perf_bp_hit, 10);
    check("perf_bp_miss", perf_bp_miss, 3);
    check("perf_exu_busy", perf_exu_busy, 2);
    do_reset();
    check("perf_bp_hit_rst", perf_bp_hit, 0);
    check("perf_bp_miss_rst", perf_bp_miss, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
